// File: rtl/an_dec_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// an_dec_pkg
// Shared constants and types for the AN-code (A = 665) double-AWE correcting
// decoder sequencer.
//   A           code multiplier
//   W_WIDTH     received codeword width
//   N_WIDTH     decoded data width
//   QW          quotient bits produced per division pass
//   CNT_WIDTH   statistics counter width
//   DELTA_WIDTH signed error-value width
//   WC_WIDTH    signed width of the corrected word W - Delta
//   REM_WIDTH   divider datapath width (holds A << (QW-1))
// ---------------------------------------------------------------------------
package an_dec_pkg;

    localparam int A           = 665;
    localparam int W_WIDTH     = 14;
    localparam int N_WIDTH     = 4;
    localparam int QW          = 5;
    localparam int CNT_WIDTH   = 16;
    localparam int DELTA_WIDTH = W_WIDTH + 1;
    localparam int WC_WIDTH    = W_WIDTH + 2;
    localparam int REM_WIDTH   = W_WIDTH + QW;
    localparam int R_WIDTH     = $clog2(A);
    localparam int K_WIDTH     = $clog2(QW);

    typedef enum logic [2:0] {
        IDLE,
        DIV1,
        LUT,
        CORR,
        DIV2,
        DONE
    } state_t;

endpackage

// File: rtl/an_dec_sequencer_if.sv
// ---------------------------------------------------------------------------
// an_dec_sequencer_if
// Codeword-in / result-out handshake bundle.
//   master : codeword source + result consumer (drives in_valid, in_w, out_ready)
//   slave  : the decoder (drives in_ready, out_valid, out_n, out_corrected,
//            out_uncorr)
// ---------------------------------------------------------------------------
interface an_dec_sequencer_if;
    import an_dec_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [W_WIDTH-1:0] in_w;
    logic               out_valid;
    logic               out_ready;
    logic [N_WIDTH-1:0] out_n;
    logic               out_corrected;
    logic               out_uncorr;

    modport master (
        output in_valid, in_w, out_ready,
        input  in_ready, out_valid, out_n, out_corrected, out_uncorr
    );

    modport slave (
        input  in_valid, in_w, out_ready,
        output in_ready, out_valid, out_n, out_corrected, out_uncorr
    );

endinterface

// File: rtl/an_dec_sequencer_lut.sv
// ---------------------------------------------------------------------------
// an_syndrome_lut
// Combinational syndrome table: remainder R -> {hit, Delta}.
//   r     in  R_WIDTH      remainder W mod A
//   hit   out 1            R is zero or maps to a known error pattern
//   delta out DELTA_WIDTH  signed error value to subtract from W (0 on miss)
// The table is enumerated at elaboration from every error of arithmetic
// weight one or two (+-2^i, +-2^i +-2^j, i < j), so nothing here is
// hand-edited. Where several patterns alias to one residue the first in
// enumeration order wins: singles before pairs, low bit positions first,
// positive sign before negative.
// ---------------------------------------------------------------------------
module an_syndrome_lut
    import an_dec_pkg::*;
(
    input  logic [R_WIDTH-1:0]            r,
    output logic                          hit,
    output logic signed [DELTA_WIDTH-1:0] delta
);

    function automatic int err_term(input int bit_pos, input int sign_sel);
        return (sign_sel == 0) ? (1 << bit_pos) : -(1 << bit_pos);
    endfunction

    function automatic int residue(input int v);
        int m;
        m = v % A;
        return (m < 0) ? m + A : m;
    endfunction

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        hit   = 1'b0;
        delta = '0;
        if (r == '0) begin
            hit = 1'b1;
        end else begin
            for (int i = 0; i < W_WIDTH; i++) begin
                for (int s = 0; s < 2; s++) begin
                    if (!hit && r == R_WIDTH'(residue(err_term(i, s)))) begin
                        hit   = 1'b1;
                        delta = DELTA_WIDTH'(err_term(i, s));
                    end
                end
            end
            for (int i = 0; i < W_WIDTH; i++) begin
                for (int j = i + 1; j < W_WIDTH; j++) begin
                    for (int s1 = 0; s1 < 2; s1++) begin
                        for (int s2 = 0; s2 < 2; s2++) begin
                            if (!hit && r == R_WIDTH'(residue(err_term(i, s1) + err_term(j, s2)))) begin
                                hit   = 1'b1;
                                delta = DELTA_WIDTH'(err_term(i, s1) + err_term(j, s2));
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/an_dec_sequencer.sv
// ---------------------------------------------------------------------------
// an_dec_sequencer
// Multi-cycle AN-code decoder: divide W by A, look up the error from the
// remainder, subtract it, and divide again to recover N. One restoring
// shift/subtract divider is shared by both passes.
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   bus            slave handshake bundle (codeword in, result out)
//   clr_cnt        in   synchronous clear of both statistics counters
//   cnt_corrected  out  saturating count of corrected words
//   cnt_uncorr     out  saturating count of uncorrectable words
// Result appears 2*QW+2 cycles after the accepting edge and is held until
// out_ready.
// ---------------------------------------------------------------------------
module an_dec_sequencer
    import an_dec_pkg::*;
#(
    parameter int CNT_BITS = CNT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    an_dec_sequencer_if.slave   bus,
    input  logic                clr_cnt,
    output logic [CNT_BITS-1:0] cnt_corrected,
    output logic [CNT_BITS-1:0] cnt_uncorr
);

    state_t                        state;
    logic [W_WIDTH-1:0]            w;
    logic [REM_WIDTH-1:0]          rem;
    logic [QW-1:0]                 q;
    logic [K_WIDTH-1:0]            k;
    logic [N_WIDTH-1:0]            q1_low;
    logic [R_WIDTH-1:0]            r;
    logic signed [DELTA_WIDTH-1:0] delta;
    logic                          hit;
    logic                          uncorr;

    logic [REM_WIDTH-1:0]          divisor;
    logic [REM_WIDTH-1:0]          rem_step;
    logic [QW-1:0]                 q_step;
    logic                          ge;
    logic                          lut_hit;
    logic signed [DELTA_WIDTH-1:0] lut_delta;
    logic signed [WC_WIDTH-1:0]    wc;
    logic                          corr_uncorr;
    logic                          fin_uncorr;
    logic                          handshake;

    an_syndrome_lut u_lut (
        .r     (r),
        .hit   (lut_hit),
        .delta (lut_delta)
    );

    // One restoring-division step, shared by DIV1 and DIV2.
    always_comb begin
        divisor  = REM_WIDTH'(A) << k;
        ge       = (rem >= divisor);
        rem_step = ge ? rem - divisor : rem;
        q_step   = q;
        if (ge) q_step[k] = 1'b1;
    end

    // Delta is sign-extended so a negative error adds back correctly.
    assign wc = $signed({{(WC_WIDTH-W_WIDTH){1'b0}}, w})
              - $signed({{(WC_WIDTH-DELTA_WIDTH){delta[DELTA_WIDTH-1]}}, delta});

    assign corr_uncorr = ~hit | wc[WC_WIDTH-1];

    // Second-pass sanity: a genuine codeword divides exactly and fits N_WIDTH.
    assign fin_uncorr = uncorr | (rem_step != '0) | (q_step[QW-1:N_WIDTH] != '0);

    assign handshake = (state == DONE) & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            w                 <= '0;
            rem               <= '0;
            q                 <= '0;
            k                 <= '0;
            q1_low            <= '0;
            r                 <= '0;
            delta             <= '0;
            hit               <= 1'b0;
            uncorr            <= 1'b0;
            bus.in_ready      <= 1'b1;
            bus.out_valid     <= 1'b0;
            bus.out_n         <= '0;
            bus.out_corrected <= 1'b0;
            bus.out_uncorr    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // branch sees the pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        w            <= bus.in_w;
                        rem          <= {{QW{1'b0}}, bus.in_w};
                        q            <= '0;
                        k            <= K_WIDTH'(QW - 1);
                        bus.in_ready <= 1'b0;
                        state        <= DIV1;
                    end
                end
                DIV1: begin
                    rem <= rem_step;
                    q   <= q_step;
                    if (k == '0) begin
                        q1_low <= q_step[N_WIDTH-1:0];
                        r      <= rem_step[R_WIDTH-1:0];
                        state  <= LUT;
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                LUT: begin
                    delta <= lut_delta;
                    hit   <= lut_hit;
                    state <= CORR;
                end
                CORR: begin
                    // An already-failed word still runs DIV2 on zero to keep latency fixed.
                    uncorr <= corr_uncorr;
                    rem    <= corr_uncorr ? '0 : {{(REM_WIDTH-WC_WIDTH){1'b0}}, wc};
                    q      <= '0;
                    k      <= K_WIDTH'(QW - 1);
                    state  <= DIV2;
                end
                DIV2: begin
                    rem <= rem_step;
                    q   <= q_step;
                    if (k == '0) begin
                        bus.out_valid     <= 1'b1;
                        bus.out_n         <= fin_uncorr ? q1_low : q_step[N_WIDTH-1:0];
                        bus.out_corrected <= (r != '0) & ~fin_uncorr;
                        bus.out_uncorr    <= fin_uncorr;
                        state             <= DONE;
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Statistics; clear takes priority over a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_corrected <= '0;
            cnt_uncorr    <= '0;
        end else if (clr_cnt) begin
            cnt_corrected <= '0;
            cnt_uncorr    <= '0;
        end else if (handshake) begin
            if (bus.out_corrected && !(&cnt_corrected)) cnt_corrected <= cnt_corrected + 1'b1;
            if (bus.out_uncorr && !(&cnt_uncorr))       cnt_uncorr    <= cnt_uncorr + 1'b1;
        end
    end

endmodule

// File: tb/tb_an_dec_sequencer.sv
// ---------------------------------------------------------------------------
// tb_an_dec_sequencer
// Self-checking bench for an_dec_sequencer. Expected results come from an
// arithmetic model (W / A, W % A, a search over weight-1/2 error values) and
// from fixed reference vectors. A second instance with 4-bit counters is
// used to reach counter saturation in a short run.
// ---------------------------------------------------------------------------
module tb_an_dec_sequencer;
    import an_dec_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic clr_cnt;
    logic clr_cnt_s;
    logic [CNT_WIDTH-1:0] cnt_c, cnt_u;
    logic [3:0] scnt_c, scnt_u;

    always #5 clk = ~clk;

    an_dec_sequencer_if bus ();
    an_dec_sequencer_if bus_s ();

    an_dec_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .clr_cnt       (clr_cnt),
        .cnt_corrected (cnt_c),
        .cnt_uncorr    (cnt_u)
    );

    an_dec_sequencer #(.CNT_BITS(4)) dut_sat (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus_s),
        .clr_cnt       (clr_cnt_s),
        .cnt_corrected (scnt_c),
        .cnt_uncorr    (scnt_u)
    );

    int vectors = 0;
    int miscompares = 0;
    int m_cnt_c = 0;
    int m_cnt_u = 0;
    int cand[$];

    // ---------------- reference model ----------------
    function automatic void build_candidates();
        cand.delete();
        for (int i = 0; i < W_WIDTH; i++) begin
            cand.push_back(1 << i);
            cand.push_back(-(1 << i));
        end
        for (int i = 0; i < W_WIDTH; i++)
            for (int j = i + 1; j < W_WIDTH; j++)
                for (int s1 = 0; s1 < 2; s1++)
                    for (int s2 = 0; s2 < 2; s2++)
                        cand.push_back((s1 ? -(1 << i) : (1 << i)) + (s2 ? -(1 << j) : (1 << j)));
    endfunction

    function automatic void model(input int wv, output int n, output bit corr, output bit unc);
        int qv, rv, d, wc;
        bit hit;
        qv  = wv / A;
        rv  = wv % A;
        hit = (rv == 0);
        d   = 0;
        if (!hit) begin
            foreach (cand[idx]) begin
                if (!hit && (((cand[idx] % A) + A) % A) == rv) begin
                    hit = 1'b1;
                    d   = cand[idx];
                end
            end
        end
        wc   = wv - d;
        unc  = !hit || (wc < 0) || ((wc % A) != 0) || ((wc / A) > 15);
        n    = unc ? (qv % 16) : (wc / A);
        corr = (rv != 0) && !unc;
    endfunction

    // ---------------- one word through the main instance ----------------
    task automatic run_word(input logic [W_WIDTH-1:0] w, input int stall, input bit hold_valid,
                            input bit clr_at_hs, input int exp_n, input bit exp_c, input bit exp_u);
        int cyc;
        bit busy_bad;
        bit unstable;
        logic [N_WIDTH-1:0] n0;
        logic c0, u0;

        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready_idle w=%0d: got %b want 1", w, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_w     = w;
        @(posedge clk);
        #1;
        if (!hold_valid) bus.in_valid = 1'b0;
        bus.in_w = ~w;
        cyc      = 0;
        busy_bad = 1'b0;
        while (bus.out_valid !== 1'b1 && cyc < 20) begin
            if (bus.in_ready !== 1'b0) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        vectors++;
        if (cyc != 12) begin
            miscompares++;
            $display("FAIL latency w=%0d: got %0d cycles want 12", w, cyc);
            if (bus.out_valid !== 1'b1) begin
                bus.in_valid = 1'b0;
                return;
            end
        end
        vectors++;
        if (busy_bad) begin
            miscompares++;
            $display("FAIL in_ready_busy w=%0d: got 1 while busy want 0", w);
        end
        vectors++;
        if (bus.out_n !== N_WIDTH'(exp_n) || bus.out_corrected !== exp_c || bus.out_uncorr !== exp_u) begin
            miscompares++;
            $display("FAIL result w=%0d: got n=%0d c=%b u=%b want n=%0d c=%b u=%b",
                     w, bus.out_n, bus.out_corrected, bus.out_uncorr, exp_n, exp_c, exp_u);
        end
        n0 = bus.out_n;
        c0 = bus.out_corrected;
        u0 = bus.out_uncorr;
        unstable = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b1 || bus.out_n !== n0 || bus.out_corrected !== c0 ||
                bus.out_uncorr !== u0 || bus.in_ready !== 1'b0) unstable = 1'b1;
        end
        if (stall > 0) begin
            vectors++;
            if (unstable) begin
                miscompares++;
                $display("FAIL stall_hold w=%0d stall=%0d: outputs moved, want held", w, stall);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        clr_cnt       = clr_at_hs;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        clr_cnt       = 1'b0;
        if (clr_at_hs) begin
            m_cnt_c = 0;
            m_cnt_u = 0;
        end else begin
            if (exp_c && m_cnt_c < 65535) m_cnt_c++;
            if (exp_u && m_cnt_u < 65535) m_cnt_u++;
        end
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release w=%0d: got valid=%b ready=%b want 0/1", w, bus.out_valid, bus.in_ready);
        end
        vectors++;
        if (cnt_c !== CNT_WIDTH'(m_cnt_c) || cnt_u !== CNT_WIDTH'(m_cnt_u)) begin
            miscompares++;
            $display("FAIL counters w=%0d: got c=%0d u=%0d want c=%0d u=%0d", w, cnt_c, cnt_u, m_cnt_c, m_cnt_u);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_n !== '0 ||
            bus.out_corrected !== 1'b0 || bus.out_uncorr !== 1'b0 || cnt_c !== '0 || cnt_u !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b vld=%b n=%0d c=%b u=%b cc=%0d cu=%0d want 1 0 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_n, bus.out_corrected, bus.out_uncorr, cnt_c, cnt_u);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        // {w, n, corrected, uncorr}
        int tbl[6][4] = '{'{3325, 5, 0, 0}, '{3326, 5, 1, 0}, '{2309, 5, 1, 0},
                          '{664, 1, 1, 0}, '{3338, 5, 0, 1}, '{53, 0, 0, 1}};
        for (int t = 0; t < 6; t++)
            run_word(W_WIDTH'(tbl[t][0]), 0, 1'b0, 1'b0, tbl[t][1], tbl[t][2] != 0, tbl[t][3] != 0);
    endtask

    task automatic test_backpressure();
        run_word(W_WIDTH'(2309), 20, 1'b0, 1'b0, 5, 1'b1, 1'b0);
    endtask

    task automatic test_hold_valid();
        run_word(W_WIDTH'(3326), 3, 1'b1, 1'b0, 5, 1'b1, 1'b0);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_w     = W_WIDTH'(3326);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_n !== '0 ||
            bus.out_corrected !== 1'b0 || bus.out_uncorr !== 1'b0 || cnt_c !== '0 || cnt_u !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: got rdy=%b vld=%b n=%0d c=%b u=%b cc=%0d cu=%0d want 1 0 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_n, bus.out_corrected, bus.out_uncorr, cnt_c, cnt_u);
        end
        m_cnt_c = 0;
        m_cnt_u = 0;
        @(negedge clk);
        rst = 1'b0;
        run_word(W_WIDTH'(2309), 0, 1'b0, 1'b0, 5, 1'b1, 1'b0);
    endtask

    task automatic test_clr();
        run_word(W_WIDTH'(3338), 0, 1'b0, 1'b0, 5, 1'b0, 1'b1);
        run_word(W_WIDTH'(3326), 0, 1'b0, 1'b1, 5, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int wv, en, e;
            bit ec, eu;
            if (t % 2 == 1) begin
                wv = int'($urandom_range(0, 16383));
            end else begin
                wv = A * int'($urandom_range(0, 15));
                e  = 0;
                for (int b = 0; b < int'($urandom_range(0, 2)); b++)
                    e += ($urandom_range(0, 1) != 0 ? 1 : -1) * (1 << $urandom_range(0, W_WIDTH - 1));
                if (wv + e >= 0 && wv + e < (1 << W_WIDTH)) wv += e;
            end
            model(wv, en, ec, eu);
            run_word(W_WIDTH'(wv), int'($urandom_range(0, 3)), 1'b0, 1'b0, en, ec, eu);
        end
    endtask

    task automatic test_saturation();
        int exp_c;
        @(negedge clk);
        bus_s.in_w      = W_WIDTH'(3326);
        bus_s.in_valid  = 1'b1;
        bus_s.out_ready = 1'b1;
        // Edge 0 accepts; each word then completes 13 edges later and the
        // next is accepted on the edge after, so handshakes land at 13+14k.
        repeat (101) @(posedge clk);
        #1;
        exp_c = (100 - 13) / 14 + 1;
        vectors++;
        if (scnt_c !== 4'(exp_c) || scnt_u !== 4'd0) begin
            miscompares++;
            $display("FAIL sat_partial: got c=%0d u=%0d want c=%0d u=0", scnt_c, scnt_u, exp_c);
        end
        repeat (200) @(posedge clk);
        #1;
        exp_c = (300 - 13) / 14 + 1;
        if (exp_c > 15) exp_c = 15;
        vectors++;
        if (scnt_c !== 4'(exp_c)) begin
            miscompares++;
            $display("FAIL sat_hold: got %0d want %0d", scnt_c, exp_c);
        end
        @(negedge clk);
        clr_cnt_s = 1'b1;
        @(negedge clk);
        clr_cnt_s      = 1'b0;
        bus_s.in_valid = 1'b0;
        vectors++;
        if (scnt_c !== 4'd0) begin
            miscompares++;
            $display("FAIL sat_clear: got %0d want 0", scnt_c);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_w        = '0;
        bus.out_ready   = 1'b0;
        bus_s.in_valid  = 1'b0;
        bus_s.in_w      = '0;
        bus_s.out_ready = 1'b0;
        clr_cnt         = 1'b0;
        clr_cnt_s       = 1'b0;
        build_candidates();
        test_reset();
        test_directed();
        test_backpressure();
        test_hold_valid();
        test_clr();
        test_mid_reset();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
